// File: rtl/io_map_pkg.sv
// Shared I/O map for the UART transmit front-end: register offsets, STATUS
// bit positions and the drain FSM state type.
package io_map_pkg;

    localparam logic [7:0] FIFO_DATA_OFS   = 8'd0;
    localparam logic [7:0] FIFO_STATUS_OFS = 8'd1;
    localparam logic [7:0] FIFO_LEVEL_OFS  = 8'd2;
    localparam logic [7:0] FIFO_BAUD_OFS   = 8'd3;

    localparam logic [7:0] UART_BAUD_OFS   = 8'd0;
    localparam logic [7:0] UART_CTRL_OFS   = 8'd1;
    localparam logic [7:0] UART_BUF_OFS    = 8'd2;

    localparam int unsigned STATUS_EMPTY_BIT    = 0;
    localparam int unsigned STATUS_FULL_BIT     = 1;
    localparam int unsigned STATUS_OVERFLOW_BIT = 2;

    localparam int unsigned UART_TX_EMPTY_BIT = 1;

    typedef enum logic [2:0] {
        DRAIN_IDLE,
        DRAIN_BAUD,
        DRAIN_POLL,
        DRAIN_CHECK,
        DRAIN_WRITE
    } drain_state_t;

    function automatic logic [7:0] status_byte(input logic overflow,
                                               input logic full,
                                               input logic empty);
        logic [7:0] s;
        s = '0;
        s[STATUS_EMPTY_BIT]    = empty;
        s[STATUS_FULL_BIT]     = full;
        s[STATUS_OVERFLOW_BIT] = overflow;
        return s;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a read-first head; pushes when full and pops when
// empty are ignored.
module sync_fifo #(
    parameter int unsigned DEPTH_LOG2 = 4,
    parameter int unsigned WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      head,
    output logic                  empty,
    output logic                  full,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = (level == '0);
    assign full    = level[DEPTH_LOG2];
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// CPU-writable transmit FIFO that masters the UART register port: forwards
// baud writes and drains queued bytes whenever the UART reports tx_empty.
module uart_tx_fifo
    import io_map_pkg::*;
#(
    parameter logic [7:0]  FIFO_ADDRESS = 8'h10,
    parameter logic [7:0]  UART_ADDRESS = 8'h00,
    parameter int unsigned DEPTH_LOG2   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic [7:0] address,
    input  logic       w_en,
    input  logic       r_en,
    output logic [7:0] dout,
    output logic [7:0] uart_address,
    output logic [7:0] uart_din,
    output logic       uart_w_en,
    output logic       uart_r_en,
    input  logic [7:0] uart_dout,
    output logic       fifo_empty
);

    localparam logic [7:0] ADDR_DATA   = FIFO_ADDRESS + FIFO_DATA_OFS;
    localparam logic [7:0] ADDR_STATUS = FIFO_ADDRESS + FIFO_STATUS_OFS;
    localparam logic [7:0] ADDR_LEVEL  = FIFO_ADDRESS + FIFO_LEVEL_OFS;
    localparam logic [7:0] ADDR_BAUD   = FIFO_ADDRESS + FIFO_BAUD_OFS;

    drain_state_t        state;
    logic [7:0]          baud;
    logic                baud_dirty;
    logic                overflow;
    logic [7:0]          head;
    logic                empty;
    logic                full;
    logic [DEPTH_LOG2:0] level;
    logic                wr_data;
    logic                wr_baud;
    logic                rd_status;
    logic                push;
    logic                pop;
    logic                tx_empty;
    logic                unused_ctrl_bits;

    assign wr_data   = w_en && (address == ADDR_DATA);
    assign wr_baud   = w_en && (address == ADDR_BAUD);
    assign rd_status = r_en && (address == ADDR_STATUS);
    assign push      = wr_data && !full;
    assign pop       = (state == DRAIN_WRITE);
    assign fifo_empty = empty;

    assign tx_empty         = uart_dout[UART_TX_EMPTY_BIT];
    assign unused_ctrl_bits = ^{uart_dout[7:2], uart_dout[0]};

    sync_fifo #(
        .DEPTH_LOG2(DEPTH_LOG2),
        .WIDTH     (8)
    ) u_fifo (
        .clk  (clk),
        .rst_n(rst_n),
        .push (push),
        .pop  (pop),
        .din  (din),
        .head (head),
        .empty(empty),
        .full (full),
        .level(level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            overflow   <= 1'b0;
            baud       <= '0;
            baud_dirty <= 1'b0;
        end else begin
            // An overflowing push outranks the clear-on-read of STATUS.
            if (wr_data && full) begin
                overflow <= 1'b1;
            end else if (rd_status) begin
                overflow <= 1'b0;
            end
            // A CPU baud write during DRAIN_BAUD keeps dirty set so the new value goes out next.
            if (wr_baud) begin
                baud       <= din;
                baud_dirty <= 1'b1;
            end else if (state == DRAIN_BAUD) begin
                baud_dirty <= 1'b0;
            end
            if (r_en) begin
                case (address)
                    ADDR_DATA:   dout <= '0;
                    ADDR_STATUS: dout <= status_byte(overflow, full, empty);
                    ADDR_LEVEL:  dout <= 8'(level);
                    ADDR_BAUD:   dout <= baud;
                    default:     dout <= '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= DRAIN_IDLE;
        end else begin
            case (state)
                DRAIN_IDLE: begin
                    if (baud_dirty) begin
                        state <= DRAIN_BAUD;
                    end else if (!empty) begin
                        state <= DRAIN_POLL;
                    end
                end
                DRAIN_BAUD:  state <= DRAIN_IDLE;
                DRAIN_POLL:  state <= DRAIN_CHECK;
                DRAIN_CHECK: state <= tx_empty ? DRAIN_WRITE : DRAIN_IDLE;
                DRAIN_WRITE: state <= DRAIN_IDLE;
                default:     state <= DRAIN_IDLE;
            endcase
        end
    end

    // Decoding straight from the state register lets reset kill a strobe at once.
    always_comb begin
        uart_address = '0;
        uart_din     = '0;
        uart_w_en    = 1'b0;
        uart_r_en    = 1'b0;
        case (state)
            DRAIN_BAUD: begin
                uart_address = UART_ADDRESS + UART_BAUD_OFS;
                uart_din     = baud;
                uart_w_en    = 1'b1;
            end
            DRAIN_POLL: begin
                uart_address = UART_ADDRESS + UART_CTRL_OFS;
                uart_r_en    = 1'b1;
            end
            DRAIN_WRITE: begin
                uart_address = UART_ADDRESS + UART_BUF_OFS;
                uart_din     = head;
                uart_w_en    = 1'b1;
            end
            default: begin
                uart_address = '0;
            end
        endcase
    end

endmodule
